// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUctr codes, MIPS opcode/funct constants, issue bundle.
// Used by the issue stage and the ALU.
// Pure definitions; no logic, no timing.
package alu_pkg;

    // ALU control codes; BEQ exists for completeness but the ALU does not act on it
    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_SUBU = 3'b001;
    localparam logic [2:0] ALU_ORI  = 3'b010;
    localparam logic [2:0] ALU_LW   = 3'b011;
    localparam logic [2:0] ALU_SW   = 3'b100;
    localparam logic [2:0] ALU_BEQ  = 3'b101;
    localparam logic [2:0] ALU_LUI  = 3'b110;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_LUI = 6'h0F;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    // Everything the EX stage needs for one instruction
    typedef struct packed {
        logic        valid;
        logic [2:0]  alu_ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store_data;
        logic [4:0]  dst;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
    } issue_t;

    localparam issue_t ISSUE_BUBBLE = '0;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID-side inputs and EX-side outputs of the ALU issue stage.
// master = issue stage (drives EX bundle), slave = environment / EX stage.
// Stall/flush flow upstream-in; hazard_stall flows back to IF/ID.
interface alu_issue_stage_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        stall;
    logic        flush;

    logic        hazard_stall;
    logic        ex_valid;
    logic [2:0]  ex_ALUctr;
    logic [31:0] ex_A;
    logic [31:0] ex_B;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dst;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_branch;
    logic        ex_illegal;

    modport master (
        input  id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
        output hazard_stall, ex_valid, ex_ALUctr, ex_A, ex_B, ex_store_data,
               ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal
    );

    modport slave (
        output id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
        input  hazard_stall, ex_valid, ex_ALUctr, ex_A, ex_B, ex_store_data,
               ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Instruction decoder: instr -> ALUctr, operand pair, flags, dst, rt_used, illegal.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is loaded.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic        id_valid,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output issue_t      dec,
    output logic        rt_used,
    output logic        illegal
);
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    issue_t      op_d;
    logic        known;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm    = instr[15:0];

    // Decode the opcode/funct into the EX bundle; unknown or absent instructions become a bubble
    always_comb begin
        op_d    = ISSUE_BUBBLE;
        known   = 1'b0;
        rt_used = 1'b0;
        op_d.a  = rs_data;
        case (opcode)
            OP_R: begin
                rt_used = 1'b1;
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    known         = 1'b1;
                    op_d.alu_ctr  = (funct == FN_ADDU) ? ALU_ADDU : ALU_SUBU;
                    op_d.b        = rt_data;
                    op_d.dst      = rd;
                    op_d.regwrite = 1'b1;
                end
            end
            OP_ORI: begin
                known         = 1'b1;
                op_d.alu_ctr  = ALU_ORI;
                op_d.b        = {16'h0, imm};
                op_d.dst      = rt;
                op_d.regwrite = 1'b1;
            end
            OP_LW: begin
                known         = 1'b1;
                op_d.alu_ctr  = ALU_LW;
                op_d.b        = {{16{imm[15]}}, imm};
                op_d.dst      = rt;
                op_d.memread  = 1'b1;
                op_d.regwrite = 1'b1;
            end
            OP_SW: begin
                rt_used         = 1'b1;
                known           = 1'b1;
                op_d.alu_ctr    = ALU_SW;
                op_d.b          = {{16{imm[15]}}, imm};
                op_d.store_data = rt_data;
                op_d.memwrite   = 1'b1;
            end
            OP_BEQ: begin
                // EX tests the SUBU result for zero; the ALU has no dedicated branch op
                rt_used      = 1'b1;
                known        = 1'b1;
                op_d.alu_ctr = ALU_SUBU;
                op_d.b       = rt_data;
                op_d.branch  = 1'b1;
            end
            OP_LUI: begin
                known         = 1'b1;
                op_d.alu_ctr  = ALU_LUI;
                op_d.b        = {imm, 16'h0};
                op_d.dst      = rt;
                op_d.regwrite = 1'b1;
            end
            default: ;
        endcase
        op_d.valid = 1'b1;
        if (op_d.dst == 5'd0) begin
            op_d.regwrite = 1'b0;
        end
        dec     = (id_valid && known) ? op_d : ISSUE_BUBBLE;
        // An all-zero word is the canonical nop, never an illegal instruction
        illegal = id_valid && !known && (instr != 32'd0);
    end
endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decode, load-use hazard detection, ID/EX pipeline register.
// Latency: 1 cycle ID to EX; hazard_stall is combinational.
// Backpressure: stall holds the EX register, flush/hazard insert a bubble (flush > stall > hazard).
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_stage_if.master io
);
    issue_t dec;
    logic   dec_rt_used;
    logic   dec_illegal;
    issue_t ex_d;
    issue_t ex_q;
    logic   illegal_d;
    logic   illegal_q;
    logic   hazard;

    alu_ctrl_dec u_dec (
        .id_valid (io.id_valid),
        .instr    (io.id_instr),
        .rs_data  (io.id_rs_data),
        .rt_data  (io.id_rt_data),
        .dec      (dec),
        .rt_used  (dec_rt_used),
        .illegal  (dec_illegal)
    );

    // Load-use compare against the EX register; deliberately independent of stall/flush
    always_comb begin
        hazard = io.id_valid && ex_q.valid && ex_q.memread && (ex_q.dst != 5'd0) &&
                 ((ex_q.dst == io.id_instr[25:21]) ||
                  (dec_rt_used && (ex_q.dst == io.id_instr[20:16])));
    end

    // Next EX register value by priority; the illegal pulse only fires on an actual load
    always_comb begin
        ex_d      = ex_q;
        illegal_d = 1'b0;
        if (io.flush) begin
            ex_d = ISSUE_BUBBLE;
        end else if (io.stall) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = ISSUE_BUBBLE;
        end else begin
            ex_d      = dec;
            illegal_d = dec_illegal;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= ISSUE_BUBBLE;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            illegal_q <= illegal_d;
        end
    end

    assign io.hazard_stall  = hazard;
    assign io.ex_valid      = ex_q.valid;
    assign io.ex_ALUctr     = ex_q.alu_ctr;
    assign io.ex_A          = ex_q.a;
    assign io.ex_B          = ex_q.b;
    assign io.ex_store_data = ex_q.store_data;
    assign io.ex_dst        = ex_q.dst;
    assign io.ex_regwrite   = ex_q.regwrite;
    assign io.ex_memread    = ex_q.memread;
    assign io.ex_memwrite   = ex_q.memwrite;
    assign io.ex_branch     = ex_q.branch;
    assign io.ex_illegal    = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with an expected-result queue.
// Inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
// Expected EX bundles are hand-written constants pushed when each step is driven.
module tb_alu_issue_stage;

    typedef struct {
        logic        valid;
        logic [2:0]  ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  dst;
        logic [4:0]  flags; // {regwrite, memread, memwrite, branch, illegal}
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t bub;

    alu_issue_stage_if io ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic v, input logic [2:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] sd,
                                input logic [4:0] d, input logic [4:0] f);
        exp_t e;
        e.valid = v; e.ctr = c; e.a = a; e.b = b; e.sd = sd; e.dst = d; e.flags = f;
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(io.ex_valid), 32'(e.valid));
        chk({tag, ".ALUctr"}, 32'(io.ex_ALUctr), 32'(e.ctr));
        chk({tag, ".A"}, io.ex_A, e.a);
        chk({tag, ".B"}, io.ex_B, e.b);
        chk({tag, ".store_data"}, io.ex_store_data, e.sd);
        chk({tag, ".dst"}, 32'(io.ex_dst), 32'(e.dst));
        chk({tag, ".flags"}, 32'({io.ex_regwrite, io.ex_memread, io.ex_memwrite,
                                  io.ex_branch, io.ex_illegal}), 32'(e.flags));
    endtask

    // One cycle: drive at the falling edge, check hazard combinationally, check EX after the edge
    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic st, input logic fl,
                        input logic hz, input exp_t e);
        exp_t got;
        io.id_valid   = 1'b1;
        io.id_instr   = instr;
        io.id_rs_data = rsd;
        io.id_rt_data = rtd;
        io.stall      = st;
        io.flush      = fl;
        sb.push_back(e);
        #1;
        chk({tag, ".hazard"}, 32'(io.hazard_stall), 32'(hz));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            got = sb.pop_front();
            cmp(tag, got);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] addu3, subu9, addu5, lw4, ill;
        checks        = 0;
        failures      = 0;
        bub           = mk(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'b00000);
        rst_n         = 1'b1;
        io.id_valid   = 1'b0;
        io.id_instr   = 32'd0;
        io.id_rs_data = 32'd0;
        io.id_rt_data = 32'd0;
        io.stall      = 1'b0;
        io.flush      = 1'b0;
        addu3 = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        subu9 = rtype(5'd1, 5'd2, 5'd9, 6'h23);
        addu5 = rtype(5'd4, 5'd1, 5'd5, 6'h21);
        lw4   = itype(6'h23, 5'd1, 5'd4, 16'h0004);
        ill   = {6'h3F, 26'd0};

        #1 rst_n = 1'b0;
        #1;
        cmp("reset", bub);
        chk("reset.hazard", 32'(io.hazard_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single-instruction decodes
        step("addu", addu3, 32'd5, 32'd7, 0, 0, 0, mk(1, 3'b000, 5, 7, 0, 3, 5'b10000));
        step("ori", itype(6'h0D, 5'd1, 5'd6, 16'h8001), 32'h10, 32'h0, 0, 0, 0,
             mk(1, 3'b010, 32'h10, 32'h00008001, 0, 6, 5'b10000));
        step("lw", itype(6'h23, 5'd1, 5'd7, 16'hFFFC), 32'h100, 32'h0, 0, 0, 0,
             mk(1, 3'b011, 32'h100, 32'hFFFFFFFC, 0, 7, 5'b11000));
        step("lui", itype(6'h0F, 5'd0, 5'd8, 16'h1234), 32'hAAAA, 32'h0, 0, 0, 0,
             mk(1, 3'b110, 32'hAAAA, 32'h12340000, 0, 8, 5'b10000));
        step("beq", itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9, 0, 0, 0,
             mk(1, 3'b001, 9, 9, 0, 0, 5'b00010));
        step("sw", itype(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h20, 32'h55, 0, 0, 0,
             mk(1, 3'b100, 32'h20, 8, 32'h55, 0, 5'b00100));

        // load-use on rs of an R-type: one bubble, then the consumer issues
        step("lu.lw", lw4, 32'h40, 32'h0, 0, 0, 0, mk(1, 3'b011, 32'h40, 4, 0, 4, 5'b11000));
        step("lu.stall", addu5, 32'h11, 32'h22, 0, 0, 1, bub);
        step("lu.issue", addu5, 32'h11, 32'h22, 0, 0, 0, mk(1, 3'b000, 32'h11, 32'h22, 0, 5, 5'b10000));

        // load to $0 never stalls and never writes
        step("lw0", itype(6'h23, 5'd1, 5'd0, 16'h0004), 32'h40, 32'h0, 0, 0, 0,
             mk(1, 3'b011, 32'h40, 4, 0, 0, 5'b01000));
        step("lw0.use", rtype(5'd0, 5'd1, 5'd5, 6'h21), 32'h0, 32'h22, 0, 0, 0,
             mk(1, 3'b000, 0, 32'h22, 0, 5, 5'b10000));

        // ori rs matches the load destination
        step("ori.lw", lw4, 32'h40, 32'h0, 0, 0, 0, mk(1, 3'b011, 32'h40, 4, 0, 4, 5'b11000));
        step("ori.stall", itype(6'h0D, 5'd4, 5'd4, 16'h0001), 32'h33, 32'h0, 0, 0, 1, bub);
        step("ori.issue", itype(6'h0D, 5'd4, 5'd4, 16'h0001), 32'h33, 32'h0, 0, 0, 0,
             mk(1, 3'b010, 32'h33, 1, 0, 4, 5'b10000));

        // ori rt matches but rt is not a source for ori
        step("ort.lw", lw4, 32'h40, 32'h0, 0, 0, 0, mk(1, 3'b011, 32'h40, 4, 0, 4, 5'b11000));
        step("ort.issue", itype(6'h0D, 5'd1, 5'd4, 16'h0002), 32'h70, 32'h0, 0, 0, 0,
             mk(1, 3'b010, 32'h70, 2, 0, 4, 5'b10000));

        // stall held 3 cycles freezes the EX register
        step("hold.load", addu3, 32'd5, 32'd7, 0, 0, 0, mk(1, 3'b000, 5, 7, 0, 3, 5'b10000));
        for (int i = 0; i < 3; i++) begin
            step("hold", subu9, 32'd1, 32'd2, 1, 0, 0, mk(1, 3'b000, 5, 7, 0, 3, 5'b10000));
        end
        step("hold.release", subu9, 32'd1, 32'd2, 0, 0, 0, mk(1, 3'b001, 1, 2, 0, 9, 5'b10000));

        // flush beats stall
        step("flush_stall", itype(6'h0D, 5'd1, 5'd6, 16'h0003), 32'h1, 32'h0, 1, 1, 0, bub);

        // stall beats hazard; hazard re-evaluates afterwards
        step("sh.lw", lw4, 32'h40, 32'h0, 0, 0, 0, mk(1, 3'b011, 32'h40, 4, 0, 4, 5'b11000));
        step("sh.hold", addu5, 32'h11, 32'h22, 1, 0, 1, mk(1, 3'b011, 32'h40, 4, 0, 4, 5'b11000));
        step("sh.bubble", addu5, 32'h11, 32'h22, 0, 0, 1, bub);
        step("sh.issue", addu5, 32'h11, 32'h22, 0, 0, 0, mk(1, 3'b000, 32'h11, 32'h22, 0, 5, 5'b10000));

        // illegal: single pulse, not repeated while held by stall
        step("ill", ill, 32'h0, 32'h0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'b00001));
        step("ill.stall1", ill, 32'h0, 32'h0, 1, 0, 0, bub);
        step("ill.stall2", ill, 32'h0, 32'h0, 1, 0, 0, bub);
        step("ill.next", addu3, 32'd5, 32'd7, 0, 0, 0, mk(1, 3'b000, 5, 7, 0, 3, 5'b10000));
        step("nop", 32'd0, 32'h5, 32'h7, 0, 0, 0, bub);

        // reset mid-operation, during a stall, takes effect without a clock edge
        step("rst.load", addu3, 32'd5, 32'd7, 0, 0, 0, mk(1, 3'b000, 5, 7, 0, 3, 5'b10000));
        io.stall = 1'b1;
        rst_n    = 1'b0;
        #1;
        cmp("rst.async", bub);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst.first", subu9, 32'd1, 32'd2, 0, 0, 0, mk(1, 3'b001, 1, 2, 0, 9, 5'b10000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage for the MIPS pipeline: decodes each ID-stage instruction into the 3-bit ALU control code and operand pair consumed by the ALU, and registers them into the ID/EX pipeline register. It also provides load-use hazard detection, stall hold and flush bubbles. It is the producer end of the ALU control interface and sits between the register file read and the EX stage.

## Interface

- No parameters; data width is fixed at 32, register index width at 5.
- Reset is asynchronous and active-low; one clock.

Ports:

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_instr  in  32  instruction word.
- id_rs_data  in  32  register file value of rs, already forwarded.
- id_rt_data  in  32  register file value of rt, already forwarded.
- stall  in  1  downstream stall; hold the EX register.
- flush  in  1  branch-taken flush; EX register becomes a bubble.
- hazard_stall  out  1  combinational load-use stall request to IF/ID.
- ex_valid  out  1  EX register holds a live instruction.
- ex_ALUctr  out  3  ALU control code.
- ex_A  out  32  ALU operand A.
- ex_B  out  32  ALU operand B.
- ex_store_data  out  32  rt value for sw.
- ex_dst  out  5  destination register; 0 if none.
- ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  control flags.
- ex_illegal  out  1  one-cycle pulse for an undecodable instruction.

## Operation

Decode rules (opcode = instr[31:26], funct = instr[5:0], imm = instr[15:0]):

- addu (op 0x00, funct 0x21): ALUctr 000, A = rs, B = rt, dst = rd, regwrite.
- subu (op 0x00, funct 0x23): ALUctr 001, A = rs, B = rt, dst = rd, regwrite.
- ori (0x0D): ALUctr 010, B = zero-extended imm, dst = rt, regwrite.
- lw (0x23): ALUctr 011, B = sign-extended imm, dst = rt, memread, regwrite.
- sw (0x2B): ALUctr 100, B = sign-extended imm, store_data = rt, memwrite, dst = 0.
- beq (0x04): ALUctr 001 (SUBU, because the ALU does not act on code 101), A = rs, B = rt, branch, dst = 0; EX tests for a zero result.
- lui (0x0F): ALUctr 110, B = {imm, 16'h0}, A = rs (don't-care), dst = rt, regwrite.
- id_instr == 0 (nop): bubble, not illegal.
- Anything else with id_valid = 1: bubble plus an ex_illegal pulse.
- A destination register of 0 forces regwrite = 0.

Hazard detection:

- rt is a source only for R-type, sw and beq.
- hazard_stall = id_valid & ex_valid & ex_memread & (ex_dst != 0) & ((ex_dst == rs) | (rt_used & ex_dst == rt)).

EX register update priority, per cycle:

1. flush: bubble.
2. stall: hold all outputs, ex_illegal = 0.
3. hazard_stall: bubble.
4. Otherwise load the decoded instruction.

A bubble means ex_valid = 0, all flags = 0, ALUctr = 000, A = B = store_data = 0, dst = 0.

## Timing

- Reset, asserted at any time including mid-stall: every output goes to the bubble value and ex_illegal = 0 immediately. The first load happens on the first rising edge after rst_n rises.
- Latency: 1 cycle from an ID instruction to the EX outputs.
- hazard_stall is purely combinational from the ID inputs and the EX register. It must not depend on the stall or flush inputs.
- Flush and stall in the same cycle: flush wins.
- Stall and hazard in the same cycle: hold. The hazard re-evaluates next cycle.
- ex_illegal is high for exactly one cycle per accepted illegal instruction. It is not repeated while the same instruction is held upstream.

## Structure

- Shared package alu_pkg holds:
  - the ALUctr constants ADDU..LUI (000..110);
  - the opcode constants (R 0x00, ORI 0x0D, LW 0x23, SW 0x2B, BEQ 0x04, LUI 0x0F);
  - the funct constants (ADDU 0x21, SUBU 0x23).
  The ALU imports the same package.
- Combinational sub-module alu_ctrl_dec covers instr → ALUctr, immediate select/extend, flags, dst, rt_used and illegal.
- The top level holds the EX register, the priority mux and the hazard compare.

## Test plan

- Reset mid-operation: rst_n low while ex_valid = 1 → all outputs 0 the same cycle, with no clock edge needed.
- Single-instruction decodes:
  - addu $3,$1,$2 with rs = 5, rt = 7 → next cycle ALUctr 000, A = 5, B = 7, dst = 3, regwrite = 1.
  - ori imm 0x8001 → B = 0x00008001.
  - lw imm 0xFFFC → B = 0xFFFFFFFC, memread = 1.
  - lui imm 0x1234 → ALUctr 110, B = 0x12340000.
- Branch and store: beq with rs = rt = 9 → ALUctr 001, branch = 1, dst = 0. sw → memwrite = 1, store_data = rt, regwrite = 0.
- Load-use hazard:
  - lw $4 followed by addu $5,$4,$1 → hazard_stall = 1 for one cycle, one bubble, then the addu issues.
  - The same sequence with lw $0 → no stall.
  - lw $4 followed by ori $4,$4 → stall, because rs matches.
- Priority: stall held 3 cycles → outputs frozen. flush + stall in the same cycle → bubble. stall + hazard → hold.
- Illegal and nop: opcode 0x3F → one ex_illegal pulse plus a bubble, and the pulse is not repeated during stall. instr = 0 → bubble with ex_illegal = 0.
